jtag_debug_sys_pio_status: RTL and testbench
============================================

// Module: jtag_debug_sys_pio_status
// PURPOSE
//   Avalon-MM slave input PIO: the read-back/status counterpart of the command output PIO.
//   Samples an external status bus through a synchronizer and latches selected edges in a
//   sticky capture register. A masked interrupt lets the JTAG debug master poll or take an IRQ.
//   Sits on the debug system interconnect beside the command PIO.
// PARAMETERS
//   WIDTH        8  status bus width (1..32)
//   SYNC_STAGES  2  synchronizer flops on in_port (>=2)
//   EDGE_TYPE    0  captured edge: 0 rising, 1 falling, 2 any
//   BIT_CLEAR    1  1: capture write clears bits where writedata=1; 0: any write clears all
// PORTS
//   clk         in   1      system clock; all logic on rising edge
//   reset       in   1      synchronous, active-high reset
//   address     in   2      word address: 0 data, 1 reserved, 2 irq mask, 3 edge capture
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe (valid with chipselect)
//   writedata   in   32     write data; only [WIDTH-1:0] used
//   in_port     in   WIDTH  asynchronous external status inputs
//   readdata    out  32     registered read data; bits [31:WIDTH] always 0
//   irq         out  1      level interrupt = |(edge_capture & irq_mask)
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-high.
//   Reset (clk edge with reset=1): sync chain, prev, irq_mask, edge_capture, readdata all 0;
//     irq therefore 0 from the following cycle.
//   Synchronizer: in_port -> SYNC_STAGES flops -> sync; prev <= sync each cycle.
//   Edge detect (comb): rise = sync & ~prev; fall = ~sync & prev; edge per EDGE_TYPE.
//   Latency: in_port stable before edge E0 -> sync valid after E(SYNC_STAGES-1)
//     -> edge_capture bit set at E(SYNC_STAGES) -> irq (comb from regs) same cycle.
//   Pulses on in_port shorter than one clk period are not guaranteed to be captured.
//   edge_capture bits are sticky: set by edge, cleared only by reset or write to address 3.
//   Write (chipselect & ~write_n):
//     addr 2: irq_mask <= writedata[WIDTH-1:0]
//     addr 3: BIT_CLEAR=1: edge_capture <= edge_capture & ~writedata; BIT_CLEAR=0: all cleared
//     addr 0/1: ignored; no side effects
//   Same-cycle edge and clear on a bit: set wins (the edge is never lost).
//   Read: readdata registered every cycle from current address; valid 1 cycle after address.
//     No read side effects. addr 0 -> sync, 1 -> 0, 2 -> irq_mask, 3 -> edge_capture.
//   chipselect is not required for reads; reads never modify state.
//   in_port high during reset: sync/prev restart from 0, so a rising edge is captured
//     SYNC_STAGES cycles after reset release (defined behaviour, not suppressed).
//   Reset mid-operation: all captured state and mask lost in that cycle; no glitch on irq
//     beyond the reset edge.
// TESTING
//   1 Reset with in_port=0 -> readdata=0 for all addresses, irq=0.
//   2 in_port 0x00->0x05, EDGE_TYPE=0 -> addr0 reads 0x05 and addr3 reads 0x05 from
//     SYNC_STAGES+1 cycles on; irq stays 0 while mask=0.
//   3 Write mask 0x04 with capture=0x05 -> irq=1 the next cycle; write 0x04 to addr 3
//     -> capture 0x01, irq=0.
//   4 Bit 0 rising edge in the same cycle as a write of 0x01 to addr 3 -> bit 0 remains 1.
//   5 EDGE_TYPE=2, toggle in_port[7] 1->0->1 -> bit 7 set after each edge; BIT_CLEAR=0
//     with any write to addr 3 -> capture=0x00.
//   6 Hold in_port=0xFF through reset -> capture=0xFF SYNC_STAGES cycles after release;
//     writes to addr 0/1 change nothing.

Source files
------------

// File: rtl/jtag_debug_sys_pio_status.sv
// Avalon-MM input PIO for the debug system: synchronised status read-back,
// sticky edge capture with per-bit clear, and a masked level interrupt.
module jtag_debug_sys_pio_status #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int BIT_CLEAR   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q, mask_q, mask_d, cap_q, cap_d;
    logic [WIDTH-1:0] sync, rise, fall, edges, wdata;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr;
    logic             unused_wd;

    assign sync      = sync_q[SYNC_STAGES-1];
    assign wdata     = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;
    assign wr        = chipselect & ~write_n;
    assign rise      = sync & ~prev_q;
    assign fall      = ~sync & prev_q;

    always_comb begin
        edges = rise;
        case (EDGE_TYPE)
            1:       edges = fall;
            2:       edges = rise | fall;
            default: edges = rise;
        endcase
    end

    // Clear is applied first and new edges OR'd after, so a coincident edge survives.
    always_comb begin
        cap_d  = cap_q;
        mask_d = mask_q;
        if (wr && address == 2'd2) mask_d = wdata;
        if (wr && address == 2'd3) cap_d = (BIT_CLEAR != 0) ? (cap_q & ~wdata) : '0;
        cap_d = cap_d | edges;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d = 32'(sync);
            2'd2:    readdata_d = 32'(mask_q);
            2'd3:    readdata_d = 32'(cap_q);
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            prev_q     <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q     <= sync;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_jtag_debug_sys_pio_status.sv
// Bench for the status PIO: three parameter variants driven in lockstep and
// compared against a history-based reference model, plus directed scenarios.
module tb_jtag_debug_sys_pio_status;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [7:0]  in_port = '0;
    logic [31:0] rd [3];
    logic        irqv [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // dut0: rising, bit-clear; dut1: falling, bit-clear, 3 sync stages; dut2: any edge, clear-all
    jtag_debug_sys_pio_status #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .BIT_CLEAR(1)) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd[0]), .irq(irqv[0]));
    jtag_debug_sys_pio_status #(.WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(1), .BIT_CLEAR(1)) dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd[1]), .irq(irqv[1]));
    jtag_debug_sys_pio_status #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .BIT_CLEAR(0)) dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd[2]), .irq(irqv[2]));

    // Reference model: the synchronised value is simply in_port as sampled S edges ago.
    int          S  [3] = '{2, 3, 2};
    int          ET [3] = '{0, 1, 2};
    int          BC [3] = '{1, 1, 0};
    logic [7:0]  hist [$];
    logic [7:0]  mcap [3];
    logic [7:0]  mmask [3];
    logic [31:0] mrd [3];

    function automatic void step_model();
        int n;
        logic [7:0] s, p, e;
        if (reset) begin
            hist = {};
            repeat (5) hist.push_back(8'h00);
            for (int d = 0; d < 3; d++) begin
                mcap[d] = '0; mmask[d] = '0; mrd[d] = '0;
            end
            return;
        end
        n = hist.size();
        for (int d = 0; d < 3; d++) begin
            s = hist[n - S[d]];
            p = hist[n - S[d] - 1];
            e = (ET[d] == 0) ? (s & ~p) : (ET[d] == 1) ? (~s & p) : (s ^ p);
            case (address)
                2'd0: mrd[d] = {24'h0, s};
                2'd2: mrd[d] = {24'h0, mmask[d]};
                2'd3: mrd[d] = {24'h0, mcap[d]};
                default: mrd[d] = '0;
            endcase
            if (chipselect && !write_n && address == 2'd3)
                mcap[d] = (BC[d] != 0) ? (mcap[d] & ~writedata[7:0]) : 8'h00;
            mcap[d] = mcap[d] | e;
            if (chipselect && !write_n && address == 2'd2) mmask[d] = writedata[7:0];
        end
        hist.push_back(in_port);
        if (hist.size() > 5) void'(hist.pop_front());
    endfunction

    function automatic logic [98:0] exp_vec();
        return {mrd[0], |(mcap[0] & mmask[0]), mrd[1], |(mcap[1] & mmask[1]),
                mrd[2], |(mcap[2] & mmask[2])};
    endfunction

    function automatic logic [98:0] act_vec();
        return {rd[0], irqv[0], rd[1], irqv[1], rd[2], irqv[2]};
    endfunction

    task automatic tick();
        step_model();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] a);
        chipselect = 1'b0; write_n = 1'b1; address = a; writedata = '0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_port = '0; idle(2'd0);
        tick(); tick();
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            idle(2'(a));
            tick();
            checks++;
            if (act_vec() !== exp_vec() || rd[0] !== 32'h0 || irqv[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset addr%0d: got %h want %h", a, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_capture();
        in_port = 8'h05; idle(2'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL capture_sync cyc%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        checks++;
        if (rd[0] !== 32'h05) begin
            errors++;
            $display("FAIL capture_data: got %h want 00000005", rd[0]);
        end
        idle(2'd3); tick();
        checks++;
        if (rd[0] !== 32'h05 || irqv[0] !== 1'b0 || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL capture_reg: got %h irq %b want 00000005 irq 0", rd[0], irqv[0]);
        end
    endtask

    task automatic test_irq_mask();
        wr(2'd2, 32'h04); tick();
        checks++;
        if (irqv[0] !== 1'b1 || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL irq_set: got %b want 1 (vec %h vs %h)", irqv[0], act_vec(), exp_vec());
        end
        wr(2'd3, 32'h04); tick();
        checks++;
        if (irqv[0] !== 1'b0 || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL irq_clear: got %b want 0", irqv[0]);
        end
        idle(2'd3); tick();
        checks++;
        if (rd[0] !== 32'h01 || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL bit_clear: got %h want 00000001", rd[0]);
        end
    endtask

    task automatic test_set_wins();
        in_port = 8'h04; idle(2'd3);
        repeat (5) tick();
        in_port = 8'h05;
        tick(); tick();
        wr(2'd3, 32'h01); tick();
        idle(2'd3); tick();
        checks++;
        if (rd[0][0] !== 1'b1 || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL set_wins: got %h want bit0=1 (vec %h vs %h)", rd[0], act_vec(), exp_vec());
        end
    endtask

    task automatic test_any_edge_clear_all();
        wr(2'd3, 32'h00); tick();
        idle(2'd3); tick();
        checks++;
        if (rd[2] !== 32'h0 || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL clear_all: got %h want 00000000", rd[2]);
        end
        in_port = 8'h85; repeat (5) tick();
        wr(2'd3, 32'h00); tick();
        idle(2'd3); tick();
        in_port = 8'h05; repeat (5) tick();
        checks++;
        if (rd[2][7] !== 1'b1 || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL any_edge_fall: got %h want bit7=1", rd[2]);
        end
        wr(2'd3, 32'h00); tick();
        idle(2'd3); tick();
        in_port = 8'h85; repeat (5) tick();
        checks++;
        if (rd[2][7] !== 1'b1 || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL any_edge_rise: got %h want bit7=1", rd[2]);
        end
    endtask

    task automatic test_reset_high();
        in_port = 8'hFF; reset = 1'b1; idle(2'd3);
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_high cyc%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        checks++;
        if (rd[0] !== 32'hFF) begin
            errors++;
            $display("FAIL reset_high_cap: got %h want 000000ff", rd[0]);
        end
        wr(2'd0, 32'hFFFF_FFFF); tick();
        wr(2'd1, 32'hFFFF_FFFF); tick();
        idle(2'd2); tick();
        checks++;
        if (rd[0] !== 32'h0 || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL ignored_wr_mask: got %h want 00000000", rd[0]);
        end
        idle(2'd3); tick();
        checks++;
        if (rd[0] !== 32'hFF || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL ignored_wr_cap: got %h want 000000ff", rd[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 59) == 0);
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 2) == 0);
            write_n    = ($urandom_range(0, 1) == 0);
            writedata  = $urandom;
            if ($urandom_range(0, 2) == 0) in_port = 8'($urandom);
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_irq_mask();
        test_set_wins();
        test_any_edge_clear_all();
        test_reset_high();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
